apb_master_bridge: RTL

- APB3 master bridge that consumes the transfer-request bundle produced by the test driver or system side.
- Request bundle: transfer, READ_WRITE, apb_read_paddr, apb_write_paddr, apb_write_data.
- Converts each request into a compliant two-phase APB transaction on one of two slaves and returns read data on apb_read_data_out.
- Address bit 8 selects the slave.
- Adds a bounded-wait watchdog so a hung slave cannot stall the bus.

---
 rtl/apb_master_bridge.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/apb_master_bridge.sv
// APB3 master bridge: turns a transfer request bundle into a two-phase APB
// transaction on one of two slaves, with a watchdog that aborts a hung slave.
module apb_master_bridge #(
    parameter int ADDR_WIDTH     = 9,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  transfer,
    input  logic                  READ_WRITE,
    input  logic [ADDR_WIDTH-1:0] apb_read_paddr,
    input  logic [ADDR_WIDTH-1:0] apb_write_paddr,
    input  logic [DATA_WIDTH-1:0] apb_write_data,
    output logic [DATA_WIDTH-1:0] apb_read_data_out,
    output logic                  psel1,
    output logic                  psel2,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata1,
    input  logic [DATA_WIDTH-1:0] prdata2,
    input  logic                  pready1,
    input  logic                  pready2,
    output logic                  xfer_done,
    output logic                  timeout_err
);

    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic                    pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [CNT_W-1:0]        wait_cnt_q, wait_cnt_d;
    logic                    xfer_done_q, xfer_done_d;
    logic                    timeout_err_q, timeout_err_d;

    logic                    capture;
    logic                    sel_hi;
    logic                    sel_ready;
    logic [DATA_WIDTH-1:0]   sel_rdata;

    // The MSB of the held address picks the slave; the other slave is ignored.
    assign sel_hi    = paddr_q[ADDR_WIDTH-1];
    assign sel_ready = sel_hi ? pready2 : pready1;
    assign sel_rdata = sel_hi ? prdata2 : prdata1;

    always_comb begin
        state_d       = state_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pwrite_d      = pwrite_q;
        rdata_d       = rdata_q;
        wait_cnt_d    = wait_cnt_q;
        xfer_done_d   = 1'b0;
        timeout_err_d = 1'b0;
        capture       = 1'b0;

        case (state_q)
            IDLE: begin
                if (transfer) begin
                    capture = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                wait_cnt_d = '0;
                state_d    = ACCESS;
            end
            ACCESS: begin
                // A ready on the final watchdog cycle still counts as success.
                if (sel_ready) begin
                    xfer_done_d = 1'b1;
                    if (!pwrite_q) begin
                        rdata_d = sel_rdata;
                    end
                    if (transfer) begin
                        capture = 1'b1;
                        state_d = SETUP;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (wait_cnt_q == LAST_WAIT) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (capture) begin
            pwrite_d = ~READ_WRITE;
            paddr_d  = READ_WRITE ? apb_read_paddr : apb_write_paddr;
            if (!READ_WRITE) begin
                pwdata_d = apb_write_data;
            end
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q       <= IDLE;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pwrite_q      <= 1'b0;
            rdata_q       <= '0;
            wait_cnt_q    <= '0;
            xfer_done_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pwrite_q      <= pwrite_d;
            rdata_q       <= rdata_d;
            wait_cnt_q    <= wait_cnt_d;
            xfer_done_q   <= xfer_done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign psel1             = (state_q != IDLE) & ~sel_hi;
    assign psel2             = (state_q != IDLE) & sel_hi;
    assign penable           = (state_q == ACCESS);
    assign pwrite            = pwrite_q;
    assign paddr             = paddr_q;
    assign pwdata            = pwdata_q;
    assign apb_read_data_out = rdata_q;
    assign xfer_done         = xfer_done_q;
    assign timeout_err       = timeout_err_q;

endmodule
